// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: access-size, data_memory enable-code and FSM encodings shared by the controller
package dmem_ctrl_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;
  localparam logic [3:0] WR_NONE   = 4'b0000;
  localparam logic [3:0] WR_BYTE0  = 4'b0001;
  localparam logic [3:0] WR_HALF0  = 4'b0101;
  localparam logic [3:0] WR_WORD   = 4'b1111;
  localparam logic [1:0] RD_NONE   = 2'b00;
  localparam logic [1:0] RD_WORD   = 2'b11;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  function automatic logic [3:0] store_code(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_BYTE ? WR_BYTE0 + {2'b00, off} :
           size == SIZE_HALF ? WR_HALF0 + {2'b00, off} : WR_WORD;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_ILL || (size == SIZE_HALF && off == 2'd3) || (size == SIZE_WORD && off != 2'd0);
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed byte/half out of a memory word and sign/zero-extends it
module dmem_load_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic [31:0] sh;
  assign sh = word_i >> {off_i, 3'b000};
  always_comb
    data_o = size_i == SIZE_BYTE ? {{24{sh[7] & ~unsigned_i}}, sh[7:0]} :
             size_i == SIZE_HALF ? {{16{sh[15] & ~unsigned_i}}, sh[15:0]} : word_i;
endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// dmem_arbiter_ctrl: two-port arbiter and access sequencer in front of the single data_memory
module dmem_arbiter_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MEM_WORDS   = 64,
  parameter bit P0_PRIORITY = 1'b0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        p0_valid_i,
  output logic        p0_ready_o,
  input  logic        p0_we_i,
  input  logic [1:0]  p0_size_i,
  input  logic        p0_unsigned_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic [31:0] p0_rdata_o,
  output logic        p0_resp_valid_o,
  output logic        p0_err_o,
  input  logic        p1_valid_i,
  output logic        p1_ready_o,
  input  logic        p1_we_i,
  input  logic [1:0]  p1_size_i,
  input  logic        p1_unsigned_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic [31:0] p1_rdata_o,
  output logic        p1_resp_valid_o,
  output logic        p1_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic [3:0]  mem_wr_enable_o,
  output logic [1:0]  mem_rd_enable_o,
  input  logic [31:0] mem_rd_data_i
);
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);
  state_e      state_q;
  logic        rr_q, port_q, we_q, uns_q;
  logic [1:0]  size_q, resp_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
  logic        tie, win, go, acc, s_we, s_uns, req_err;
  logic [1:0]  s_size, win_mask, port_mask;
  logic [31:0] s_addr, s_wdata, load_data;
  assign tie       = p0_valid_i & p1_valid_i;
  assign win       = tie ? (P0_PRIORITY ? 1'b0 : rr_q) : ~p0_valid_i;
  // ready is gated by reset so every output reads 0 the moment reset rises
  assign go        = state_q == IDLE && (p0_valid_i || p1_valid_i) && !reset_i;
  assign p0_ready_o = go & ~win;
  assign p1_ready_o = go & win;
  assign s_we      = win ? p1_we_i : p0_we_i;
  assign s_uns     = win ? p1_unsigned_i : p0_unsigned_i;
  assign s_size    = win ? p1_size_i : p0_size_i;
  assign s_addr    = win ? p1_addr_i : p0_addr_i;
  assign s_wdata   = win ? p1_wdata_i : p0_wdata_i;
  assign req_err   = misaligned(s_size, s_addr[1:0]) || s_addr >= ADDR_LIMIT;
  assign win_mask  = win ? 2'b10 : 2'b01;
  assign port_mask = port_q ? 2'b10 : 2'b01;
  dmem_load_align u_align (
    .word_i    (mem_rd_data_i),
    .off_i     (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_o    (load_data)
  );
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= SIZE_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          port_q  <= win;
          we_q    <= s_we;
          uns_q   <= s_uns;
          size_q  <= s_size;
          addr_q  <= s_addr;
          wdata_q <= s_wdata;
          if (tie && !P0_PRIORITY) rr_q <= ~win;
          state_q <= req_err ? RESP : ACCESS;
          resp_q  <= req_err ? win_mask : 2'b00;
          err_q   <= req_err ? win_mask : 2'b00;
        end
        ACCESS: begin
          state_q <= RESP;
          resp_q  <= port_mask;
          if (port_q) rdata1_q <= we_q ? '0 : load_data;
          else rdata0_q <= we_q ? '0 : load_data;
        end
        RESP: begin
          state_q  <= IDLE;
          resp_q   <= '0;
          err_q    <= '0;
          rdata0_q <= '0;
          rdata1_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign acc             = state_q == ACCESS;
  assign mem_addr_o      = acc ? {2'b00, addr_q[31:2]} : '0;
  assign mem_wr_data_o   = acc && we_q ? wdata_q : '0;
  assign mem_wr_enable_o = acc && we_q ? store_code(size_q, addr_q[1:0]) : WR_NONE;
  assign mem_rd_enable_o = acc && !we_q ? RD_WORD : RD_NONE;
  assign p0_resp_valid_o = resp_q[0];
  assign p1_resp_valid_o = resp_q[1];
  assign p0_err_o        = err_q[0];
  assign p1_err_o        = err_q[1];
  assign p0_rdata_o      = rdata0_q;
  assign p1_rdata_o      = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// tb_dmem_arbiter_ctrl: directed scoreboard bench with a behavioural data_memory behind the controller
module tb_dmem_arbiter_ctrl;
  localparam int MEM_WORDS = 64;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] v = '0, we = '0, uns = '0, rdy, rv, er;
  logic [1:0] sz [2];
  logic [31:0] ad [2], wd [2], rd [2];
  logic [31:0] maddr, mwd, mrd;
  logic [3:0] mwe;
  logic [1:0] mre;
  logic [31:0] mem [MEM_WORDS] = '{default: '0};
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int port; logic err; logic [31:0] data; int at;} exp_t;
  exp_t sb [$];

  dmem_arbiter_ctrl #(.MEM_WORDS(MEM_WORDS), .P0_PRIORITY(1'b0)) dut (
    .clock_i(clk), .reset_i(rst),
    .p0_valid_i(v[0]), .p0_ready_o(rdy[0]), .p0_we_i(we[0]), .p0_size_i(sz[0]),
    .p0_unsigned_i(uns[0]), .p0_addr_i(ad[0]), .p0_wdata_i(wd[0]), .p0_rdata_o(rd[0]),
    .p0_resp_valid_o(rv[0]), .p0_err_o(er[0]),
    .p1_valid_i(v[1]), .p1_ready_o(rdy[1]), .p1_we_i(we[1]), .p1_size_i(sz[1]),
    .p1_unsigned_i(uns[1]), .p1_addr_i(ad[1]), .p1_wdata_i(wd[1]), .p1_rdata_o(rd[1]),
    .p1_resp_valid_o(rv[1]), .p1_err_o(er[1]),
    .mem_addr_o(maddr), .mem_wr_data_o(mwd), .mem_wr_enable_o(mwe),
    .mem_rd_enable_o(mre), .mem_rd_data_i(mrd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] code(input logic [1:0] s, input logic [1:0] o);
    case ({s, o})
      4'b0000: return 4'h1;
      4'b0001: return 4'h2;
      4'b0010: return 4'h3;
      4'b0011: return 4'h4;
      4'b0100: return 4'h5;
      4'b0101: return 4'h6;
      4'b0110: return 4'h7;
      4'b1000: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] c, input logic [31:0] d);
    logic [31:0] m, r;
    int sh;
    case (c)
      4'h1: begin m = 32'h000000FF; sh = 0;  end
      4'h2: begin m = 32'h0000FF00; sh = 8;  end
      4'h3: begin m = 32'h00FF0000; sh = 16; end
      4'h4: begin m = 32'hFF000000; sh = 24; end
      4'h5: begin m = 32'h0000FFFF; sh = 0;  end
      4'h6: begin m = 32'h00FFFF00; sh = 8;  end
      4'h7: begin m = 32'hFFFF0000; sh = 16; end
      4'hF: begin m = 32'hFFFFFFFF; sh = 0;  end
      default: begin m = 32'h0; sh = 0; end
    endcase
    r = c == 4'hF ? d : c >= 4'h5 ? {16'h0, d[15:0]} : {24'h0, d[7:0]};
    return (old & ~m) | ((r << sh) & m);
  endfunction

  assign mrd = mre == 2'b11 ? mem[maddr[5:0]] : 32'h0;
  always @(posedge clk) if (mwe != 4'h0) mem[maddr[5:0]] <= merge(mem[maddr[5:0]], mwe, mwd);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && |rv) begin
      if (sb.size() == 0) chk("unexpected_resp", {30'b0, rv}, 32'h0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_port", {30'b0, rv}, e.port == 1 ? 32'h2 : 32'h1);
        chk("resp_err", {31'b0, er[e.port]}, {31'b0, e.err});
        chk("resp_rdata", rd[e.port], e.data);
        chk("resp_cycle", cyc, e.at);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 8) begin @(negedge clk); #2; n++; end
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic req(input int p, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d, input logic e, input logic [31:0] r);
    int n = 0;
    @(negedge clk);
    we[p] = w; sz[p] = s; uns[p] = u; ad[p] = a; wd[p] = d; v[p] = 1'b1;
    #1;
    while (!rdy[p] && n < 20) begin @(negedge clk); #1; n++; end
    chk("ready", {31'b0, rdy[p]}, 32'h1);
    sb.push_back('{p, e, r, cyc + (e ? 1 : 2)});
    @(posedge clk);
    #1 v[p] = 1'b0;
    @(negedge clk);
    chk("mem_addr", maddr, e ? 32'h0 : {2'b00, a[31:2]});
    chk("mem_wr_en", {28'b0, mwe}, (e || !w) ? 32'h0 : {28'b0, code(s, a[1:0])});
    chk("mem_rd_en", {30'b0, mre}, (e || w) ? 32'h0 : 32'h3);
    chk("mem_wdata", mwd, (e || !w) ? 32'h0 : d);
    drain();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {30'b0, rdy}, 32'h0);
    chk({tag, "_resp_err"}, {28'b0, rv, er}, 32'h0);
    chk({tag, "_rdata"}, rd[0] | rd[1], 32'h0);
    chk({tag, "_mem"}, maddr | mwd | {28'b0, mwe} | {30'b0, mre}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin sz[i] = W; ad[i] = '0; wd[i] = '0; end
    v[0] = 1'b1;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    v = '0;
    rst = 1'b0;
    req(0, 1, W, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    req(0, 0, W, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    req(0, 0, B, 0, 32'h13, 32'h0, 0, 32'hFFFFFFDE);
    req(0, 0, B, 1, 32'h13, 32'h0, 0, 32'h000000DE);
    req(0, 0, H, 0, 32'h12, 32'h0, 0, 32'hFFFFDEAD);
    req(1, 0, H, 1, 32'h10, 32'h0, 0, 32'h0000BEEF);
    req(1, 0, B, 0, 32'h11, 32'h0, 0, 32'hFFFFFFBE);
    req(0, 1, H, 0, 32'h21, 32'h1234, 0, 32'h0);
    req(1, 0, W, 0, 32'h20, 32'h0, 0, 32'h00123400);
    req(1, 1, B, 0, 32'h27, 32'hAB, 0, 32'h0);
    req(0, 0, W, 0, 32'h24, 32'h0, 0, 32'hAB000000);
    req(1, 1, W, 0, 32'hFC, 32'h5, 0, 32'h0);
    req(1, 0, W, 0, 32'hFC, 32'h0, 0, 32'h5);
    req(0, 0, H, 0, 32'h23, 32'h0, 1, 32'h0);
    req(0, 0, W, 0, MEM_WORDS * 4, 32'h0, 1, 32'h0);
    req(0, 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0);
    req(1, 0, W, 0, 32'h12, 32'h0, 1, 32'h0);
    req(1, 1, W, 0, MEM_WORDS * 4, 32'h77, 1, 32'h0);
    // first tie after reset: pointer starts at port 0
    @(negedge clk);
    we = '0; uns = '0; sz[0] = W; sz[1] = W; ad[0] = 32'h10; ad[1] = 32'h20; v = 2'b11;
    #1 chk("tie1_grant", {30'b0, rdy}, 32'h1);
    sb.push_back('{0, 1'b0, 32'hDEADBEEF, cyc + 2});
    @(posedge clk);
    #1 v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); #1 chk("tie1_p1_wait", {30'b0, rdy}, 32'h0); end
    @(negedge clk);
    #1 chk("tie1_p1_grant", {30'b0, rdy}, 32'h2);
    sb.push_back('{1, 1'b0, 32'h00123400, cyc + 2});
    @(posedge clk);
    #1 v[1] = 1'b0;
    drain();
    @(negedge clk);
    ad[0] = 32'h24; ad[1] = 32'h10; v = 2'b11;
    #1 chk("tie2_grant", {30'b0, rdy}, 32'h2);
    sb.push_back('{1, 1'b0, 32'hDEADBEEF, cyc + 2});
    @(posedge clk);
    #1 v[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); #1 chk("tie2_p0_wait", {30'b0, rdy}, 32'h0); end
    @(negedge clk);
    #1 chk("tie2_p0_grant", {30'b0, rdy}, 32'h1);
    sb.push_back('{0, 1'b0, 32'hAB000000, cyc + 2});
    @(posedge clk);
    #1 v[0] = 1'b0;
    drain();
    // reset while a store is in ACCESS must abort it
    req(0, 1, W, 0, 32'h30, 32'h11223344, 0, 32'h0);
    @(negedge clk);
    we[0] = 1'b1; sz[0] = W; ad[0] = 32'h30; wd[0] = 32'hA5A5A5A5; v[0] = 1'b1;
    #1 chk("abort_ready", {31'b0, rdy[0]}, 32'h1);
    @(posedge clk);
    #1 v[0] = 1'b0;
    @(negedge clk);
    chk("abort_access", {28'b0, mwe}, 32'hF);
    #1 rst = 1'b1;
    #1 chk_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    req(0, 0, W, 0, 32'h30, 32'h0, 0, 32'h11223344);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
